// File: rtl/cpu15_pkg.sv
// Shared opcode, FSM-state and shift-mode encodings for the execute/write-back stage.
package cpu15_pkg;

    localparam int DW_DEF  = 16;
    localparam int SHW_DEF = 4;

    localparam logic [4:0] OP_MOV = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_SL  = 5'd5;
    localparam logic [4:0] OP_SR  = 5'd6;
    localparam logic [4:0] OP_SRA = 5'd7;
    localparam logic [4:0] OP_LDL = 5'd8;
    localparam logic [4:0] OP_LDH = 5'd9;
    localparam logic [4:0] OP_CMP = 5'd10;
    localparam logic [4:0] OP_JE  = 5'd11;
    localparam logic [4:0] OP_JMP = 5'd12;
    localparam logic [4:0] OP_HLT = 5'd13;
    localparam logic [4:0] OP_JC  = 5'd14;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [1:0] SH_SL  = 2'd0;
    localparam logic [1:0] SH_SR  = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

endpackage

// File: rtl/exec_shifter.sv
// Iterative 1-bit/cycle shifter; done flags the cycle whose edge produces the final value.
module exec_shifter
    import cpu15_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [DW-1:0]  data_in,
    input  logic [SHW-1:0] amount,
    output logic           busy,
    output logic           done,
    output logic [DW-1:0]  result
);

    logic [DW-1:0]  tmp_q, tmp_d, shifted;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [1:0]     mode_q, mode_d;

    always_comb begin
        case (mode_q)
            SH_SL:   shifted = {tmp_q[DW-2:0], 1'b0};
            SH_SR:   shifted = {1'b0, tmp_q[DW-1:1]};
            default: shifted = {tmp_q[DW-1], tmp_q[DW-1:1]};
        endcase
    end

    always_comb begin
        tmp_d  = tmp_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (start) begin
            tmp_d  = data_in;
            cnt_d  = amount;
            mode_d = mode;
        end else if (cnt_q != '0) begin
            tmp_d = shifted;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmp_q  <= '0;
            cnt_q  <= '0;
            mode_q <= SH_SL;
        end else begin
            tmp_q  <= tmp_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign busy   = (cnt_q != '0);
    assign done   = (cnt_q == SHW'(1));
    assign result = shifted;

endmodule

// File: rtl/reg_exec.sv
// Execute/write-back stage owning the 8-entry register file.
// Optional carry flag and JC opcode enabled by defining REG_EXEC_CARRY_FLAG_EN.
module reg_exec
    import cpu15_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int SHW = SHW_DEF
) (
    input  logic          CLK_EX,
    input  logic          RESET,
    input  logic          VALID_IN,
    output logic          READY_OUT,
    input  logic [4:0]    OP_CODE,
    input  logic [2:0]    N_REG_A,
    input  logic [2:0]    N_REG_B,
    input  logic [DW-1:0] REG_B,
    input  logic [7:0]    IMM,
    output logic [DW-1:0] REG_0,
    output logic [DW-1:0] REG_1,
    output logic [DW-1:0] REG_2,
    output logic [DW-1:0] REG_3,
    output logic [DW-1:0] REG_4,
    output logic [DW-1:0] REG_5,
    output logic [DW-1:0] REG_6,
    output logic [DW-1:0] REG_7,
    output logic          FLAG_EQ,
    output logic          PC_LOAD,
    output logic [7:0]    PC_TARGET,
    output logic          HALTED
`ifdef REG_EXEC_CARRY_FLAG_EN
    ,
    output logic          FLAG_C
`endif
);

    logic [DW-1:0] rf_q [8];
    logic [DW-1:0] rf_d [8];
    logic [1:0]    state_q, state_d;
    logic [2:0]    dest_q, dest_d;
    logic          flag_eq_q, flag_eq_d;
    logic          pc_load_q, pc_load_d;
    logic [7:0]    pc_target_q, pc_target_d;

    logic          accept, is_shift, sh_start, sh_busy, sh_done;
    logic [1:0]    sh_mode;
    logic [DW-1:0] a_val, sh_result;

    // Source index is consumed by decode; B arrives already resolved on REG_B.
    logic unused_n_reg_b;
    assign unused_n_reg_b = ^N_REG_B;

    assign accept   = VALID_IN && (state_q == ST_RUN);
    assign a_val    = rf_q[N_REG_A];
    assign is_shift = (OP_CODE == OP_SL) || (OP_CODE == OP_SR) || (OP_CODE == OP_SRA);
    assign sh_start = accept && is_shift && (REG_B[SHW-1:0] != '0);
    assign sh_mode  = (OP_CODE == OP_SL) ? SH_SL : (OP_CODE == OP_SR) ? SH_SR : SH_SRA;

    exec_shifter #(
        .DW  (DW),
        .SHW (SHW)
    ) u_shifter (
        .clk     (CLK_EX),
        .reset   (RESET),
        .start   (sh_start),
        .mode    (sh_mode),
        .data_in (a_val),
        .amount  (REG_B[SHW-1:0]),
        .busy    (sh_busy),
        .done    (sh_done),
        .result  (sh_result)
    );

`ifdef REG_EXEC_CARRY_FLAG_EN
    logic          flag_c_q, flag_c_d;
    logic [DW:0]   add_ext;
    assign add_ext = {1'b0, a_val} + {1'b0, REG_B};
    assign FLAG_C  = flag_c_q;
`endif

    always_comb begin
        rf_d        = rf_q;
        state_d     = state_q;
        dest_d      = dest_q;
        flag_eq_d   = flag_eq_q;
        pc_load_d   = 1'b0;
        pc_target_d = pc_target_q;
`ifdef REG_EXEC_CARRY_FLAG_EN
        flag_c_d    = flag_c_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    case (OP_CODE)
                        OP_MOV: rf_d[N_REG_A] = REG_B;
                        OP_ADD: begin
                            rf_d[N_REG_A] = a_val + REG_B;
`ifdef REG_EXEC_CARRY_FLAG_EN
                            flag_c_d = add_ext[DW];
`endif
                        end
                        OP_SUB: begin
                            rf_d[N_REG_A] = a_val - REG_B;
`ifdef REG_EXEC_CARRY_FLAG_EN
                            flag_c_d = (a_val < REG_B);
`endif
                        end
                        OP_AND: rf_d[N_REG_A] = a_val & REG_B;
                        OP_OR:  rf_d[N_REG_A] = a_val | REG_B;
                        OP_LDL: rf_d[N_REG_A] = {a_val[DW-1:8], IMM};
                        OP_LDH: rf_d[N_REG_A] = {IMM, a_val[7:0]};
                        OP_CMP: flag_eq_d = (a_val == REG_B);
                        OP_JMP: begin
                            pc_load_d   = 1'b1;
                            pc_target_d = IMM;
                        end
                        OP_JE: begin
                            if (flag_eq_q) begin
                                pc_load_d   = 1'b1;
                                pc_target_d = IMM;
                            end
                        end
`ifdef REG_EXEC_CARRY_FLAG_EN
                        OP_JC: begin
                            if (flag_c_q) begin
                                pc_load_d   = 1'b1;
                                pc_target_d = IMM;
                            end
                        end
`endif
                        OP_HLT: state_d = ST_HALT;
                        OP_SL, OP_SR, OP_SRA: begin
                            // Zero-length shifts complete in place without stalling.
                            if (sh_start) begin
                                dest_d  = N_REG_A;
                                state_d = ST_SHIFT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    rf_d[dest_q] = sh_result;
                    state_d      = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_EX) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            state_q     <= ST_RUN;
            dest_q      <= '0;
            flag_eq_q   <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
`ifdef REG_EXEC_CARRY_FLAG_EN
            flag_c_q    <= 1'b0;
`endif
        end else begin
            rf_q        <= rf_d;
            state_q     <= state_d;
            dest_q      <= dest_d;
            flag_eq_q   <= flag_eq_d;
            pc_load_q   <= pc_load_d;
            pc_target_q <= pc_target_d;
`ifdef REG_EXEC_CARRY_FLAG_EN
            flag_c_q    <= flag_c_d;
`endif
        end
    end

    assign READY_OUT = (state_q == ST_RUN);
    assign HALTED    = (state_q == ST_HALT);
    assign FLAG_EQ   = flag_eq_q;
    assign PC_LOAD   = pc_load_q;
    assign PC_TARGET = pc_target_q;
    assign REG_0 = rf_q[0];
    assign REG_1 = rf_q[1];
    assign REG_2 = rf_q[2];
    assign REG_3 = rf_q[3];
    assign REG_4 = rf_q[4];
    assign REG_5 = rf_q[5];
    assign REG_6 = rf_q[6];
    assign REG_7 = rf_q[7];

endmodule

// File: tb/tb_reg_exec.sv
// Directed bench for reg_exec; carry checks run when REG_EXEC_CARRY_FLAG_EN is defined.
module tb_reg_exec;
    import cpu15_pkg::*;

    logic        clk = 1'b0;
    logic        RESET, VALID_IN, READY_OUT, FLAG_EQ, PC_LOAD, HALTED;
    logic [4:0]  OP_CODE;
    logic [2:0]  N_REG_A, N_REG_B;
    logic [15:0] REG_B;
    logic [7:0]  IMM, PC_TARGET;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
`ifdef REG_EXEC_CARRY_FLAG_EN
    logic        FLAG_C;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int stall;

    always #5 clk = ~clk;

    reg_exec dut (
        .CLK_EX    (clk),
        .RESET     (RESET),
        .VALID_IN  (VALID_IN),
        .READY_OUT (READY_OUT),
        .OP_CODE   (OP_CODE),
        .N_REG_A   (N_REG_A),
        .N_REG_B   (N_REG_B),
        .REG_B     (REG_B),
        .IMM       (IMM),
        .REG_0     (r0),
        .REG_1     (r1),
        .REG_2     (r2),
        .REG_3     (r3),
        .REG_4     (r4),
        .REG_5     (r5),
        .REG_6     (r6),
        .REG_7     (r7),
        .FLAG_EQ   (FLAG_EQ),
        .PC_LOAD   (PC_LOAD),
        .PC_TARGET (PC_TARGET),
        .HALTED    (HALTED)
`ifdef REG_EXEC_CARRY_FLAG_EN
        ,
        .FLAG_C    (FLAG_C)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single accepting edge, then drop VALID_IN.
    task automatic send(input logic [4:0] op, input logic [2:0] na, input logic [15:0] b,
                        input logic [7:0] imm);
        OP_CODE  = op;
        N_REG_A  = na;
        N_REG_B  = 3'd0;
        REG_B    = b;
        IMM      = imm;
        VALID_IN = 1'b1;
        tick();
        VALID_IN = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!READY_OUT && cycles < 40) begin
            cycles++;
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_r0"}, {16'h0, r0}, 32'h0);
        chk({tag, "_r1"}, {16'h0, r1}, 32'h0);
        chk({tag, "_r2"}, {16'h0, r2}, 32'h0);
        chk({tag, "_r3"}, {16'h0, r3}, 32'h0);
        chk({tag, "_r4"}, {16'h0, r4}, 32'h0);
        chk({tag, "_r5"}, {16'h0, r5}, 32'h0);
        chk({tag, "_r6"}, {16'h0, r6}, 32'h0);
        chk({tag, "_r7"}, {16'h0, r7}, 32'h0);
    endtask

    initial begin
        RESET = 1'b1; VALID_IN = 1'b0; OP_CODE = OP_MOV; N_REG_A = 0; N_REG_B = 0;
        REG_B = 0; IMM = 0;
        tick(); tick();
        RESET = 1'b0;

        // Reset state
        chk_all_zero("rst");
        chk("rst_ready", READY_OUT, 1);
        chk("rst_halted", HALTED, 0);
        chk("rst_flag_eq", FLAG_EQ, 0);
        chk("rst_pc_load", PC_LOAD, 0);
        chk("rst_pc_target", PC_TARGET, 0);

        // Immediate loads and ALU ops
        send(OP_LDH, 3'd1, 16'h0, 8'h12);  chk("ldh_r1", r1, 16'h1200);
        send(OP_LDL, 3'd1, 16'h0, 8'h34);  chk("ldl_r1", r1, 16'h1234);
        send(OP_LDH, 3'd2, 16'h0, 8'hFF);
        send(OP_LDL, 3'd2, 16'h0, 8'hFF);  chk("ld_r2", r2, 16'hFFFF);
        send(OP_ADD, 3'd2, 16'h1234, 8'h0); chk("add_wrap", r2, 16'h1233);
        chk("add_r1_keep", r1, 16'h1234);
        send(OP_SUB, 3'd1, 16'h0034, 8'h0); chk("sub_r1", r1, 16'h1200);
        send(OP_SUB, 3'd0, 16'h0001, 8'h0); chk("sub_wrap", r0, 16'hFFFF);
        send(OP_MOV, 3'd4, 16'hBEEF, 8'h0); chk("mov_r4", r4, 16'hBEEF);
        send(OP_AND, 3'd4, 16'h0FF0, 8'h0); chk("and_r4", r4, 16'h0EE0);
        send(OP_OR,  3'd4, 16'h1001, 8'h0); chk("or_r4", r4, 16'h1EE1);

        // SRA by 4 with a follow-on ADD held during the stall
        send(OP_LDH, 3'd3, 16'h0, 8'h80);
        send(OP_LDL, 3'd3, 16'h0, 8'h00);  chk("ld_r3", r3, 16'h8000);
        send(OP_SRA, 3'd3, 16'h0004, 8'h0);
        OP_CODE = OP_ADD; N_REG_A = 3'd5; REG_B = 16'h0001; VALID_IN = 1'b1;
        stall = 0;
        while (!READY_OUT && stall < 40) begin
            stall++;
            chk("sra_r3_hold", r3, 16'h8000);
            tick();
        end
        chk("sra_stall_cycles", stall, 4);
        chk("sra_r3", r3, 16'hF800);
        chk("held_not_early", r5, 16'h0000);
        tick();
        VALID_IN = 1'b0;
        chk("held_once", r5, 16'h0001);
        tick();
        chk("held_no_dup", r5, 16'h0001);

        // Zero-length shift: amount bits are zero even though REG_B is not
        send(OP_SRA, 3'd3, 16'h0010, 8'h0);
        chk("sra0_ready", READY_OUT, 1);
        chk("sra0_r3", r3, 16'hF800);
        send(OP_SL, 3'd3, 16'h0001, 8'h0);
        wait_ready(stall);
        chk("sl1_stall", stall, 1);
        chk("sl1_r3", r3, 16'hF000);
        send(OP_SR, 3'd3, 16'h0003, 8'h0);
        wait_ready(stall);
        chk("sr3_stall", stall, 3);
        chk("sr3_r3", r3, 16'h1E00);

        // Compare and conditional jumps
        send(OP_LDL, 3'd6, 16'h0, 8'h05);  chk("ldl_r6", r6, 16'h0005);
        send(OP_CMP, 3'd6, 16'h0005, 8'h0);
        chk("cmp_eq", FLAG_EQ, 1);
        chk("cmp_no_write", r6, 16'h0005);
        chk("cmp_no_pc", PC_LOAD, 0);
        send(OP_JE, 3'd0, 16'h0, 8'h2A);
        chk("je_taken", PC_LOAD, 1);
        chk("je_target", PC_TARGET, 8'h2A);
        tick();
        chk("je_pulse_end", PC_LOAD, 0);
        send(OP_CMP, 3'd6, 16'h0006, 8'h0);
        chk("cmp_ne", FLAG_EQ, 0);
        send(OP_JE, 3'd0, 16'h0, 8'h55);
        chk("je_not_taken", PC_LOAD, 0);
        chk("je_target_hold", PC_TARGET, 8'h2A);
        send(OP_JMP, 3'd0, 16'h0, 8'h11);
        chk("jmp_load", PC_LOAD, 1);
        chk("jmp_target", PC_TARGET, 8'h11);
        send(5'h1F, 3'd6, 16'hFFFF, 8'hFF);
        chk("undef_nop", r6, 16'h0005);
        chk("undef_no_pc", PC_LOAD, 0);

`ifdef REG_EXEC_CARRY_FLAG_EN
        send(OP_LDH, 3'd7, 16'h0, 8'hFF);
        send(OP_LDL, 3'd7, 16'h0, 8'hFF);
        send(OP_ADD, 3'd7, 16'h0001, 8'h0);
        chk("addc_r7", r7, 16'h0000);
        chk("addc_flag", FLAG_C, 1);
        send(OP_LDL, 3'd7, 16'h0, 8'h03);
        send(OP_ADD, 3'd7, 16'h0001, 8'h0);
        chk("add_nc_flag", FLAG_C, 0);
        send(OP_SUB, 3'd7, 16'h0006, 8'h0);
        chk("subb_r7", r7, 16'hFFFE);
        chk("subb_flag", FLAG_C, 1);
        send(OP_JC, 3'd0, 16'h0, 8'h3C);
        chk("jc_taken", PC_LOAD, 1);
        chk("jc_target", PC_TARGET, 8'h3C);
`else
        send(OP_JC, 3'd0, 16'h0, 8'h3C);
        chk("jc_nop", PC_LOAD, 0);
        chk("jc_nop_target", PC_TARGET, 8'h11);
`endif

        // Reset during an in-flight shift aborts it
        send(OP_SL, 3'd3, 16'h000F, 8'h0);
        tick(); tick();
        chk("mid_shift_busy", READY_OUT, 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk_all_zero("abort");
        chk("abort_ready", READY_OUT, 1);
        chk("abort_halted", HALTED, 0);
        tick(); tick();
        chk("abort_no_write", r3, 16'h0000);

        // Halt is absorbing until reset
        send(OP_LDL, 3'd1, 16'h0, 8'h42);
        send(OP_HLT, 3'd0, 16'h0, 8'h0);
        chk("hlt_halted", HALTED, 1);
        chk("hlt_ready", READY_OUT, 0);
        OP_CODE = OP_MOV; N_REG_A = 3'd1; REG_B = 16'h9999; VALID_IN = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        VALID_IN = 1'b0;
        chk("hlt_r1_hold", r1, 16'h0042);
        chk("hlt_still", HALTED, 1);
        chk("hlt_ready_low", READY_OUT, 0);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("hlt_rst_halted", HALTED, 0);
        chk("hlt_rst_ready", READY_OUT, 1);
        chk("hlt_rst_r1", r1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
